// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiply is shift-add and divide is restoring, one bit per cycle for WIDTH
// cycles. The result commits to HI/LO on a single edge, together with a
// one-cycle done pulse.
// Optional feature: define MULDIV_SIGNED_EN to make MULT/DIV two's-complement.
// Without it, MULT/DIV behave as MULTU/DIVU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    // Two's-complement negate when neg is set; applied to operands and results.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             dbz_pend;

    logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier being shifted out / quotient shifted in
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic             is_div;
    logic             neg_q;      // negate product / quotient at commit
    logic             neg_r;      // negate remainder at commit

    logic             signed_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             op_arith;
    logic             op_div;
    logic             b_zero;
    logic             launch;
    logic             dbz_req;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
`else
    assign signed_op = 1'b0;
`endif

    assign sign_a   = signed_op & A[WIDTH-1];
    assign sign_b   = signed_op & B[WIDTH-1];
    assign mag_a    = cond_neg(A, sign_a);
    assign mag_b    = cond_neg(B, sign_b);
    assign op_arith = ~op[2];
    assign op_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign b_zero   = (B == '0);
    assign launch   = (state == S_IDLE) && start && op_arith && !(op_div && b_zero);
    assign dbz_req  = (state == S_IDLE) && start && op_div && b_zero;

    assign busy = (state == S_RUN);

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, opnd};
        div_part = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd};
        nxt_hi   = acc_hi;
        nxt_lo   = acc_lo;
        if (is_div) begin
            // Partial remainder stays below the divisor, so bit WIDTH of the
            // difference is a reliable borrow flag.
            if (!div_diff[WIDTH]) begin
                nxt_hi = div_diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_part[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_lo[0]) begin
                {nxt_hi, nxt_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
            end else begin
                {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
            end
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Sign correction of the finished magnitudes, consumed only at commit.
    always_comb begin
        prod_fix = cond_neg2({acc_hi, acc_lo}, neg_q);
        quot_fix = cond_neg(acc_lo, neg_q);
        rem_fix  = cond_neg(acc_hi, neg_r);
    end

    // Control FSM: IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE, plus divide-by-zero bypass.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dbz_pend    <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        dbz_pend <= 1'b0;
                    end else if (dbz_req) begin
                        state    <= S_DONE;
                        dbz_pend <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done        <= 1'b1;
                    div_by_zero <= dbz_pend;
                    dbz_pend    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand latch at launch and per-cycle iteration of the working registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (launch) begin
            acc_hi <= '0;
            acc_lo <= op_div ? mag_a : mag_b;
            opnd   <= op_div ? mag_b : mag_a;
            is_div <= op_div;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
        end else if (state == S_RUN) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

    // Architectural HI/LO: written by MTHI/MTLO in IDLE or by the DONE commit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            HI <= '0;
            LO <= '0;
        end else if (state == S_IDLE && start && op == OP_MTHI) begin
            HI <= A;
        end else if (state == S_IDLE && start && op == OP_MTLO) begin
            LO <= A;
        end else if (state == S_DONE && !dbz_pend) begin
            if (is_div) begin
                HI <= rem_fix;
                LO <= quot_fix;
            end else begin
                HI <= prod_fix[2*WIDTH-1:WIDTH];
                LO <= prod_fix[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written multi-cycle sequences
// for muldiv_unit at WIDTH=32. Expected values follow MULDIV_SIGNED_EN when defined.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic         CLK;
    logic         RST_N;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation, scramble A/B while it runs, and check latency,
    // HI/LO stability mid-run, the committed result and the single done pulse.
    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz, input int elat);
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        int lat;
        @(negedge CLK);
        hi0   = HI;
        lo0   = LO;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        lat   = 0;
        for (int k = 1; k <= W + 8; k++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k == W / 2) begin
                check({nm, " busy mid"}, {63'd0, busy}, 64'd1);
                check({nm, " HI held"}, {32'd0, HI}, {32'd0, hi0});
                check({nm, " LO held"}, {32'd0, LO}, {32'd0, lo0});
            end
        end
        check({nm, " latency"}, 64'(lat), 64'(elat));
        check({nm, " HI"}, {32'd0, HI}, {32'd0, ehi});
        check({nm, " LO"}, {32'd0, LO}, {32'd0, elo});
        check({nm, " dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
        @(posedge CLK);
        #1;
        check({nm, " done 1 cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic done_seen;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{MULTU, 32'd3,        32'd4,        32'h00000000, 32'h0000000C};
        vecs[2] = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[3] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[5] = '{DIVU,  32'd5,        32'd9,        32'd5,        32'd0};
        vecs[6] = '{MULT,  32'd7,        32'd6,        32'd0,        32'd42};
`ifdef MULDIV_SIGNED_EN
        vecs[7]  = '{DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[8]  = '{MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[9]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
`else
        vecs[7]  = '{DIV,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vecs[8]  = '{MULT, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
        vecs[9]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[10] = '{DIV,  32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000};
`endif

        RST_N = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset HI", {32'd0, HI}, 64'd0);
        check("reset LO", {32'd0, LO}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0, W + 1);
        end

        // MTHI then divide by zero: HI keeps the moved value, LO untouched.
        @(negedge CLK);
        start = 1'b1; op = MTHI; A = 32'h00001234;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("mthi HI", {32'd0, HI}, 64'h1234);
        check("mthi done", {63'd0, done}, 64'd0);
        check("mthi busy", {63'd0, busy}, 64'd0);
        run_op("divu0", DIVU, 32'd10, 32'd0, 32'h00001234, vecs[NV-1].lo, 1'b1, 1);

        // MTLO in IDLE writes next cycle; the same request during RUN is ignored.
        @(negedge CLK);
        start = 1'b1; op = MTLO; A = 32'hA5A5A5A5;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("mtlo LO", {32'd0, LO}, 64'hA5A5A5A5);
        check("mtlo done", {63'd0, done}, 64'd0);
        check("mtlo busy", {63'd0, busy}, 64'd0);

        @(negedge CLK);
        start = 1'b1; op = MULTU; A = 32'd3; B = 32'd4;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        start = 1'b1; op = MTLO; A = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("mtlo in run LO", {32'd0, LO}, 64'hA5A5A5A5);
        check("mtlo in run busy", {63'd0, busy}, 64'd1);
        done_seen = 1'b0;
        for (int k = 0; k < W + 8; k++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
        end
        check("mul after mtlo done", {63'd0, done_seen}, 64'd1);
        check("mul after mtlo LO", {32'd0, LO}, 64'd12);
        check("mul after mtlo HI", {32'd0, HI}, 64'd0);

        // Reserved op code: nothing starts, nothing changes.
        @(negedge CLK);
        start = 1'b1; op = 3'b110; A = 32'h55555555; B = 32'h3;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("reserved busy", {63'd0, busy}, 64'd0);
        done_seen = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            done_seen = done_seen | done;
        end
        check("reserved done", {63'd0, done_seen}, 64'd0);
        check("reserved HI", {32'd0, HI}, 64'd0);
        check("reserved LO", {32'd0, LO}, 64'd12);

        // Reset at RUN cycle 10, together with a DIVU start request.
        @(negedge CLK);
        start = 1'b1; op = MULTU; A = 32'd3; B = 32'd4;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        check("abort busy before", {63'd0, busy}, 64'd1);
        start = 1'b1; op = DIVU; A = 32'd100; B = 32'd3; RST_N = 1'b0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        RST_N = 1'b1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort HI", {32'd0, HI}, 64'd0);
        check("abort LO", {32'd0, LO}, 64'd0);
        done_seen = 1'b0;
        for (int k = 0; k < W + 8; k++) begin
            @(posedge CLK);
            #1;
            done_seen = done_seen | done;
        end
        check("abort no done", {63'd0, done_seen}, 64'd0);
        check("abort LO after", {32'd0, LO}, 64'd0);

        // Reset wins over a start request in IDLE.
        @(negedge CLK);
        start = 1'b1; op = MULTU; A = 32'd9; B = 32'd9; RST_N = 1'b0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        RST_N = 1'b1;
        check("rst prio busy", {63'd0, busy}, 64'd0);
        @(posedge CLK);
        #1;
        check("rst prio busy next", {63'd0, busy}, 64'd0);

        // Normal operation resumes after reset.
        run_op("post reset", MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, W + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
